rf_read_arbiter: RTL and testbench

- Shares the single 8:1 x 16-bit register-file read mux among NUM_REQ requesters.
- Round-robin arbitration picks one requester per cycle and drives the mux select.
- Registers the mux output and returns it, with a per-requester valid pulse.
- Sits between the register-file mux and the units that read operands from it.

---
 rtl/rf_pkg.sv | 7 +
 rtl/rf_rr_pick.sv | 24 ++
 rtl/rf_read_arbiter.sv | 63 ++++++
 tb/tb_rf_read_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and FSM state type for the register-file read arbiter
package rf_pkg;
  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;
  localparam int RF_NUM_REGS = 8;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
endpackage

// File: rtl/rf_rr_pick.sv
// rf_rr_pick: round-robin winner search starting just after the last grant
module rf_rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any_valid
);
  always_comb begin
    onehot = '0;
    idx = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any_valid && cand[(int'(last) + k) % N]) begin
        any_valid = 1'b1;
        idx = IW'((int'(last) + k) % N);
      end
    end
    onehot[idx] = any_valid;
  end
endmodule

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: round-robin sharing of one register-file read mux with registered data return
module rf_read_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] raddr,
  output logic [ADDR_W-1:0]         mux_sel,
  input  logic [DATA_W-1:0]         mux_y,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata
);
  localparam int LW = $clog2(NUM_REQ);
  state_e state_q, state_d;
  logic [LW-1:0] last_q, last_d, win_idx;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d, win_oh;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic win_any, busy;
  rf_rr_pick #(.N(NUM_REQ), .IW(LW)) u_pick (
    .cand(req & ~gnt_q),
    .last(last_q),
    .onehot(win_oh),
    .idx(win_idx),
    .any_valid(win_any)
  );
  always_comb begin
    busy = state_q == ST_BUSY;
    state_d = win_any ? ST_BUSY : ST_IDLE;
    gnt_d = win_any ? win_oh : '0;
    sel_d = win_any ? raddr[win_idx*ADDR_W +: ADDR_W] : sel_q;
    last_d = win_any ? win_idx : last_q;
    rvalid_d = busy ? gnt_q : '0;
    rdata_d = busy ? mux_y : rdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q <= LW'(NUM_REQ - 1);
      gnt_q <= '0;
      rvalid_q <= '0;
      sel_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      rvalid_q <= rvalid_d;
      sel_q <= sel_d;
      rdata_q <= rdata_d;
    end
  end
  assign gnt = gnt_q;
  assign rvalid = rvalid_q;
  assign mux_sel = sel_q;
  assign rdata = rdata_q;
endmodule

// File: tb/tb_rf_read_arbiter.sv
// tb_rf_read_arbiter: directed self-checking bench for the register-file read arbiter
module tb_rf_read_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [11:0] raddr = '0;
  logic [2:0] mux_sel;
  logic [15:0] mux_y, rdata;
  logic [3:0] gnt, rvalid;
  int checks = 0;
  int errors = 0;
  assign mux_y = {4'h0, 3'b0, mux_sel[2], 3'b0, mux_sel[1], 3'b0, mux_sel[0]};
  always #5 clk = ~clk;
  rf_read_arbiter #(.NUM_REQ(4), .DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .raddr(raddr),
    .mux_sel(mux_sel),
    .mux_y(mux_y),
    .gnt(gnt),
    .rvalid(rvalid),
    .rdata(rdata)
  );
  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want %b", gnt, 4'b0000); end
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid got %b want %b", rvalid, 4'b0000); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h want %h", rdata, 16'h0000); end
    checks++; if (mux_sel !== 3'd0) begin errors++; $display("FAIL reset_mux_sel got %0d want %0d", mux_sel, 0); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b0100;
    raddr[6 +: 3] = 3'd7;
    @(posedge clk);
    #1;
    req = '0;
    @(posedge clk);
    #2;
    checks++; if (rdata !== 16'h0111) begin errors++; $display("FAIL pre_reset_rdata got %h want %h", rdata, 16'h0111); end
    rst = 1'b1;
    #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL async_reset_rdata got %h want %h", rdata, 16'h0000); end
    checks++; if (mux_sel !== 3'd0) begin errors++; $display("FAIL async_reset_mux_sel got %0d want %0d", mux_sel, 0); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL async_reset_gnt got %b want %b", gnt, 4'b0000); end
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL async_reset_rvalid got %b want %b", rvalid, 4'b0000); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic test_single_read;
    do_reset();
    req = 4'b0001;
    raddr[0 +: 3] = 3'd5;
    @(posedge clk);
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b want %b", gnt, 4'b0001); end
    checks++; if (mux_sel !== 3'd5) begin errors++; $display("FAIL single_mux_sel got %0d want %0d", mux_sel, 5); end
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL single_early_rvalid got %b want %b", rvalid, 4'b0000); end
    req = '0;
    @(posedge clk);
    #1;
    checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL single_rvalid got %b want %b", rvalid, 4'b0001); end
    checks++; if (rdata !== 16'h0101) begin errors++; $display("FAIL single_rdata got %h want %h", rdata, 16'h0101); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_drop got %b want %b", gnt, 4'b0000); end
    @(posedge clk);
    #1;
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL single_rvalid_drop got %b want %b", rvalid, 4'b0000); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_idle_gnt got %b want %b", gnt, 4'b0000); end
  endtask
  task automatic test_all_four;
    logic [3:0] eg[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    logic [3:0] ev[5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [15:0] ed[5] = '{16'h0000, 16'h0001, 16'h0010, 16'h0011, 16'h0111};
    do_reset();
    raddr = {3'd7, 3'd3, 3'd2, 3'd1};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if (gnt !== eg[i]) begin errors++; $display("FAIL all4_gnt[%0d] got %b want %b", i, gnt, eg[i]); end
      checks++; if (rvalid !== ev[i]) begin errors++; $display("FAIL all4_rvalid[%0d] got %b want %b", i, rvalid, ev[i]); end
      checks++; if (rdata !== ed[i]) begin errors++; $display("FAIL all4_rdata[%0d] got %h want %h", i, rdata, ed[i]); end
      req = req & ~eg[i];
    end
  endtask
  task automatic test_fairness;
    logic [3:0] eg, ev;
    logic [15:0] ed;
    do_reset();
    raddr = '0;
    raddr[0 +: 3] = 3'd6;
    raddr[6 +: 3] = 3'd4;
    req = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      eg = (i % 2 == 0) ? 4'b0001 : 4'b0100;
      ev = (i == 0) ? 4'b0000 : ((i % 2 == 1) ? 4'b0001 : 4'b0100);
      ed = (i == 0) ? 16'h0000 : ((i % 2 == 1) ? 16'h0110 : 16'h0100);
      @(posedge clk);
      #1;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL fair_gnt[%0d] got %b want %b", i, gnt, eg); end
      checks++; if (rvalid !== ev) begin errors++; $display("FAIL fair_rvalid[%0d] got %b want %b", i, rvalid, ev); end
      checks++; if (rdata !== ed) begin errors++; $display("FAIL fair_rdata[%0d] got %h want %h", i, rdata, ed); end
    end
    req = '0;
  endtask
  task automatic test_solo_hold;
    logic [3:0] eg, ev;
    logic [15:0] ed;
    do_reset();
    raddr = '0;
    raddr[3 +: 3] = 3'd3;
    req = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      eg = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      ev = (i % 2 == 1) ? 4'b0010 : 4'b0000;
      ed = (i == 0) ? 16'h0000 : 16'h0011;
      @(posedge clk);
      #1;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL solo_gnt[%0d] got %b want %b", i, gnt, eg); end
      checks++; if (rvalid !== ev) begin errors++; $display("FAIL solo_rvalid[%0d] got %b want %b", i, rvalid, ev); end
      checks++; if (rdata !== ed) begin errors++; $display("FAIL solo_rdata[%0d] got %h want %h", i, rdata, ed); end
    end
    req = '0;
  endtask
  task automatic test_reset_busy;
    do_reset();
    raddr = '0;
    raddr[9 +: 3] = 3'd5;
    raddr[0 +: 3] = 3'd2;
    req = 4'b1000;
    @(posedge clk);
    #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rbusy_gnt got %b want %b", gnt, 4'b1000); end
    req = '0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rbusy_gnt_clear got %b want %b", gnt, 4'b0000); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL rbusy_no_rvalid got %b want %b", rvalid, 4'b0000); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL rbusy_rdata got %h want %h", rdata, 16'h0000); end
    req = 4'b1001;
    @(posedge clk);
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rbusy_first_gnt got %b want %b", gnt, 4'b0001); end
    checks++; if (mux_sel !== 3'd2) begin errors++; $display("FAIL rbusy_mux_sel got %0d want %0d", mux_sel, 2); end
    req = 4'b1000;
    @(posedge clk);
    #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rbusy_second_gnt got %b want %b", gnt, 4'b1000); end
    checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL rbusy_rvalid0 got %b want %b", rvalid, 4'b0001); end
    checks++; if (rdata !== 16'h0010) begin errors++; $display("FAIL rbusy_rdata0 got %h want %h", rdata, 16'h0010); end
    req = '0;
    @(posedge clk);
    #1;
    checks++; if (rvalid !== 4'b1000) begin errors++; $display("FAIL rbusy_rvalid3 got %b want %b", rvalid, 4'b1000); end
    checks++; if (rdata !== 16'h0101) begin errors++; $display("FAIL rbusy_rdata3 got %h want %h", rdata, 16'h0101); end
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_all_four();
    test_fairness();
    test_solo_hold();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
